// File: rtl/mips_mem_responder.sv
// mips_mem_responder: word-addressed DEPTH x 32 memory that serves an
// instruction-fetch port (read-only) and a data port (lw/sw).
// The data port has fixed priority over the instruction port.
// Each access completes a fixed LATENCY edges after its grant and is
// acknowledged by a one-cycle pulse on the port's ack output.
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag addresses >= DEPTH
// on err, suppress out-of-range stores and return 0 for out-of-range reads.
// Without it, the upper address bits are ignored and err is tied to 0.
module mips_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [CW-1:0] cnt_q,     cnt_d;
  logic          gnt_d_q,   gnt_d_d;
  logic          we_q,      we_d;
  logic [31:0]   addr_q,    addr_d;
  logic [31:0]   wdata_q,   wdata_d;
  logic          i_ack_q,   i_ack_d;
  logic          d_ack_q,   d_ack_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          err_q,     err_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          access;
  logic          oob;
  logic          mem_we;

`ifdef MEM_BOUNDS_CHECK_EN
  assign oob = |addr_q[31:AW];
`else
  logic unused_addr_hi;
  assign oob            = 1'b0;
  assign unused_addr_hi = ^addr_q[31:AW];
`endif

  assign idx     = addr_q[AW-1:0];
  assign rd_word = mem[idx];
  assign access  = (state_q == S_WAIT) && (cnt_q == '0);
  assign mem_we  = access && gnt_d_q && we_q && !oob;

  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;

  // Next-state logic: arbitration, latency countdown and response generation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d_d   = gnt_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (d_req) begin
          gnt_d_d = 1'b1;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end else if (i_req) begin
          gnt_d_d = 1'b0;
          we_d    = 1'b0;
          addr_d  = i_addr;
          cnt_d   = CW'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_RESP;
          err_d   = oob;
          if (gnt_d_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = (we_q || oob) ? '0 : rd_word;
          end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = oob ? '0 : rd_word;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers, cleared asynchronously
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_d_q   <= gnt_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  // Storage array: written only on a store's access edge, never reset
  always_ff @(posedge clk1) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: directed scenarios plus randomized
// transactions compared against a word-array reference model.
module tb_mips_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, busy, err;
  logic [31:0] i_rdata, d_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] exp_i, exp_d;

  mips_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One complete transaction on either port, checked against the model.
  task automatic txn(input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit scramble);
    int unsigned n;
    int unsigned idx;
    bit          got;
    bit          out_of_range;
    logic [31:0] rd;
    idx          = addr % DEPTH;
    out_of_range = BOUNDS && (addr >= DEPTH);
    rd           = out_of_range ? 32'h0 : model[idx];
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk1); #1;
      n++;
      if (n == 1) check("busy_in_txn", busy, 1);
      if (scramble && n == 1) begin
        d_addr = $urandom; d_wdata = $urandom; i_addr = $urandom; d_we = ~we;
      end
      got = is_d ? d_ack : i_ack;
    end
    check("ack_seen", got, 1);
    check("latency", n, LAT + 1);
    check("err_with_ack", err, out_of_range);
    if (is_d) begin
      check("no_i_ack", i_ack, 0);
      if (we) begin
        check("store_rdata_zero", d_rdata, 0);
        if (!out_of_range) model[idx] = wdata;
        exp_d = 32'h0;
      end else begin
        check("load_rdata", d_rdata, rd);
        exp_d = rd;
      end
      check("i_rdata_hold", i_rdata, exp_i);
      d_req = 1'b0;
    end else begin
      check("no_d_ack", d_ack, 0);
      check("fetch_rdata", i_rdata, rd);
      exp_i = rd;
      check("d_rdata_hold", d_rdata, exp_d);
      i_req = 1'b0;
    end
    @(posedge clk1); #1;
    check("ack_one_cycle", is_d ? d_ack : i_ack, 0);
    check("idle_after", busy, 0);
    check("err_cleared", err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n, dn, in_;
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    exp_i = '0; exp_d = '0;
    repeat (3) @(posedge clk1);
    #1;
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk1); #1;

    // store then load of address 5
    txn(1, 1, 32'd5, 32'hDEADBEEF, 0);
    txn(1, 0, 32'd5, 32'h0, 0);
    check("load_deadbeef", d_rdata, 32'hDEADBEEF);

    // fill the low window so every later read has a known value
    for (int unsigned a = 0; a < 32; a++) txn(1, 1, a, $urandom, 0);
    txn(1, 1, 32'd7, 32'h11, 0);
    txn(1, 1, 32'd3, 32'h22, 0);
    txn(1, 1, 32'd12, 32'h0, 0);
    txn(1, 1, 32'd4, 32'h44, 0);

    // simultaneous requests: data first, fetch LAT+2 cycles later
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd7;
    i_req = 1'b1; i_addr = 32'd3;
    n = 0; dn = 0; in_ = 0;
    while ((dn == 0 || in_ == 0) && n < 40) begin
      @(posedge clk1); #1;
      n++;
      if (d_ack && dn == 0) begin
        dn = n;
        check("sim_d_rdata", d_rdata, 32'h11);
        check("sim_single_ack_d", i_ack, 0);
        d_req = 1'b0;
      end
      if (i_ack && in_ == 0) begin
        in_ = n;
        check("sim_i_rdata", i_rdata, 32'h22);
        check("sim_single_ack_i", d_ack, 0);
        i_req = 1'b0;
      end
    end
    check("sim_d_latency", dn, LAT + 1);
    check("sim_i_gap", in_ - dn, LAT + 2);
    exp_d = 32'h11; exp_i = 32'h22;
    @(posedge clk1); #1;

    // store followed by an immediate fetch of the same word
    txn(1, 1, 32'd9, 32'hA5A5A5A5, 0);
    txn(0, 0, 32'd9, 32'h0, 0);
    check("fetch_after_store", i_rdata, 32'hA5A5A5A5);

    // reset during WAIT abandons the store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd12; d_wdata = 32'hCAFEF00D;
    @(posedge clk1); #1;
    check("rst_mid_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_d_ack", d_ack, 0);
    check("rst_mid_i_ack", i_ack, 0);
    check("rst_mid_busy_low", busy, 0);
    check("rst_mid_d_rdata", d_rdata, 0);
    d_req = 1'b0;
    #1 rst_n = 1'b1;
    exp_d = '0; exp_i = '0;
    @(posedge clk1); #1;
    txn(1, 0, 32'd12, 32'h0, 0);
    check("aborted_store", d_rdata, 32'h0);

    // out-of-range store, then read back the aliased word
    txn(1, 1, DEPTH + 4, 32'h77, 0);
    txn(1, 0, 32'd4, 32'h0, 0);
    check("alias_read", d_rdata, BOUNDS ? 32'h44 : 32'h77);
    txn(0, 0, 32'd4, 32'h0, 0);

    // inputs changed after the grant are ignored
    txn(1, 1, 32'd20, 32'h12345678, 1);
    txn(1, 0, 32'd20, 32'h0, 1);
    check("scramble_load", d_rdata, 32'h12345678);
    txn(0, 0, 32'd20, 32'h0, 1);

    // randomized traffic
    for (int unsigned k = 0; k < 60; k++) begin
      bit          is_d, we, scr;
      logic [31:0] addr;
      is_d = 1'($urandom_range(0, 1));
      we   = is_d && ($urandom_range(0, 1) == 1);
      scr  = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 31);
      if ($urandom_range(0, 4) == 0) addr = addr + DEPTH * $urandom_range(1, 7);
      txn(is_d, we, addr, $urandom, scr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
